// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main-memory level-change request
// interface. Holds the responder FSM state type and the default geometry
// constants that the cache side also uses.
package mem_if_pkg;

  // Responder FSM: IDLE = last request complete, BUSY = access in flight.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  localparam int MEM_DATA_W    = 32;
  localparam int MEM_ADDR_BITS = 8;

endpackage

// File: rtl/ram_array.sv
// Single-port word storage: synchronous write, synchronous (read-first) read.
// Not reset; contents are undefined until written.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable
//   idx   - word index (read and write share it)
//   wdata - write data
//   rdata - registered read data of mem[idx] from the previous edge
module ram_array
  import mem_if_pkg::*;
#(
  parameter int DATA_W    = MEM_DATA_W,
  parameter int ADDR_BITS = MEM_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the level-change request interface. Any change
// on data/addr/wr (or the first cycle after reset) starts a transaction;
// ready (state) drops while busy and rises LATENCY edges after detection,
// with read data presented on q.
// Optional build macro: RAM_RESPONDER_STAT_EN adds rd_count/wr_count.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   data     - write data
//   addr     - word address (only low ADDR_BITS index the array)
//   wr       - 1 = write, 0 = read
//   state    - ready: 1 = idle/complete, 0 = busy
//   q        - read data, held until the next read completes
//   rd_count - completed reads   (RAM_RESPONDER_STAT_EN only)
//   wr_count - completed writes  (RAM_RESPONDER_STAT_EN only)
module ram_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_W    = MEM_DATA_W,
  parameter int ADDR_BITS = MEM_ADDR_BITS,
  parameter int LATENCY   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic [31:0]       addr,
  input  logic              wr,
  output logic              state,
  output logic [DATA_W-1:0] q
`ifdef RAM_RESPONDER_STAT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  mem_state_e        fsm_q, fsm_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [31:0]       addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              armed_q, armed_d;
  logic              state_q, state_d;
  logic [DATA_W-1:0] q_q, q_d;

  logic              new_req, done, rd_done, wr_done;
  logic [DATA_W-1:0] rdata;

  // Full 32-bit address compare: an aliasing address change is still a new
  // request even though it hits the same word.
  assign new_req = (data != data_q) | (addr != addr_q) | (wr != wr_q) | !armed_q;
  assign done    = !new_req && (fsm_q == BUSY) && (cnt_q == 8'd0);
  assign rd_done = done && !wr_q;
  assign wr_done = done && wr_q;

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    armed_d = armed_q;
    state_d = state_q;
    q_d     = q_q;
    if (new_req) begin
      // A new request always wins, silently dropping any access in flight.
      data_d  = data;
      addr_d  = addr;
      wr_d    = wr;
      armed_d = 1'b1;
      state_d = 1'b0;
      cnt_d   = 8'(LATENCY - 1);
      fsm_d   = BUSY;
    end else if (fsm_q == BUSY) begin
      if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        state_d = 1'b1;
        fsm_d   = IDLE;
        if (!wr_q) q_d = rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      cnt_q   <= 8'd0;
      data_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      armed_q <= 1'b0;
      state_q <= 1'b1;
      q_q     <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      armed_q <= armed_d;
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  // The array is indexed by the next-state address so its registered read
  // already targets the new word on the detection edge; this is what makes
  // LATENCY=1 return the right data. On the completion edge addr_d equals
  // addr_q, so the write lands on the latched index.
  ram_array #(
    .DATA_W   (DATA_W),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (wr_done),
    .idx  (addr_d[ADDR_BITS-1:0]),
    .wdata(data_q),
    .rdata(rdata)
  );

  assign state = state_q;
  assign q     = q_q;

`ifdef RAM_RESPONDER_STAT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      if (rd_done) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_done) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the level-change request interface that the cache uses toward main memory.
- The requester holds data/addr/wr stable. Any change on those inputs starts a new transaction.
- The block models a word-addressed RAM with a configurable access latency. It drops ready while busy and raises it when the access completes, with read data on q.
- It replaces the zero-latency RAM model so that cache miss and stall paths are exercised.

Parameters:
- DATA_W, 32: data width in bits.
- ADDR_BITS, 8: index bits; depth is 2**ADDR_BITS words.
- LATENCY, 3: cycles from request detection to completion; legal range 1..255.

Ports:
- clk: input, 1 bit. Rising-edge clock.
- rst: input, 1 bit. Asynchronous, active-high reset.
- data: input, DATA_W bits. Write data.
- addr: input, 32 bits. Word address; only addr[ADDR_BITS-1:0] is used, upper bits alias.
- wr: input, 1 bit. 1 = write, 0 = read.
- state: output, 1 bit. Ready: 1 = idle or last request complete, 0 = busy.
- q: output, DATA_W bits. Read data, held until the next read completes.

Behaviour:
- Reset values:
  - state=1, q=0, FSM=IDLE, cnt=0.
  - Latched data/addr/wr = 0.
  - armed=0.
  - Memory array is not reset.
- Reset asserted mid-transaction aborts it; a pending write is discarded.
- Request detection, sampled each posedge: new = (data!=data_l) | (addr!=addr_l) | (wr!=wr_l) | !armed.
- On new:
  - latch the inputs; armed<=1; state<=0; cnt<=LATENCY-1; FSM<=BUSY.
  - This applies in any FSM state.
- BUSY, inputs stable:
  - if cnt!=0: cnt<=cnt-1.
  - if cnt==0:
    - wr=1: mem[idx]<=data_l.
    - wr=0: q<=mem[idx].
    - Then state<=1 and FSM<=IDLE.
- Completion timing: detection at edge N, completion at edge N+LATENCY. For LATENCY=1, completion is at edge N+1.
- Mid-access change: an input change while BUSY restarts the count with the new request. The old request has no side effects; an aborted write is not performed.
- IDLE with stable inputs:
  - no memory access.
  - no duplicate write.
  - state stays 1; q holds.
- A write never changes q.
- A read issued after a write to the same index returns the new data.
- idx = addr_l[ADDR_BITS-1:0].
- cnt width = 8 bits.

Optional Feature:
- Macro: RAM_RESPONDER_STAT_EN.
- With the macro defined, two extra output ports exist, each 32 bits and reset to 0:
  - rd_count: increments at each read completion.
  - wr_count: increments at each write completion.
  - Aborted requests are not counted. Both counters wrap at 2**32.
- Without the macro, the ports and counters are absent. Core behaviour is identical in both builds.

Decomposition:
- Shared package mem_if_pkg holds:
  - FSM state typedef {IDLE, BUSY}.
  - Default DATA_W and ADDR_BITS constants, also used by the cache.
- One sub-module, ram_array: single-port, synchronous-write, synchronous-read storage with ports clk, we, idx, wdata, rdata.
- The FSM, latency counter and request detection stay in ram_responder.

Test Plan:
- Reset mid-access: assert rst during a BUSY write; release; read the same addr → state=1 and q=0 during reset. The aborted write data is absent (mem holds its prior value, preloaded as 0x0).
- Basic write then read, LATENCY=3: write addr=5 data=0xDEADBEEF; state falls at detect and rises 3 edges later. Then read addr=5 → q=0xDEADBEEF 3 edges after detect.
- Abort: start a write to addr=7 data=0x11; change data to 0x22 after 1 cycle. A subsequent read of addr=7 → 0x22. Completion occurs LATENCY edges after the second change.
- Aliasing and hold, ADDR_BITS=8: write addr=0x105 data=0xA5; read addr=0x005 → 0xA5. Hold the request 10 cycles → state stays 1, no new access.
- LATENCY=1 and first cycle after reset: read addr=0 with data=0 and wr=0 immediately after reset → still treated as new; state=0 for one edge, then 1.
- Statistics (build with RAM_RESPONDER_STAT_EN): 3 reads, 2 writes, 1 aborted write → rd_count=3, wr_count=2.
